// File: rtl/fifo_pkg.sv
// Shared sizing constants and payload type for the single-clock byte FIFO.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : fifo_pkg

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage array with one write port and a registered read port.
//   clk    : rising-edge clock
//   rst    : async active-low reset (clears the read register only)
//   we     : write enable; wdata stored at waddr on the edge
//   waddr  : write address
//   wdata  : write data
//   re     : read enable; mem[raddr] captured into rdata on the edge
//   raddr  : read address
//   rdata  : registered read data, holds between accepted reads
module sync_fifo_mem
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  data_t                 wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output data_t                 rdata
);

  data_t mem [DEPTH];
  data_t rdata_q;

  // Storage words are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: only an accepted read updates it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock 16-slot byte FIFO, 15 usable entries, registered read data.
//   clk   : rising-edge clock
//   rst   : async active-low reset
//   wr    : write request, din sampled on the same edge
//   rd    : read request
//   din   : write data
//   dout  : registered read data
//   empty : stored count == 0
//   full  : stored count == DEPTH-1
module sync_fifo
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr,
  input  logic  rd,
  input  data_t din,
  output data_t dout,
  output logic  empty,
  output logic  full
);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] wptr_d;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH-1:0] rptr_d;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic                  wr_ok_c;
  logic                  rd_ok_c;

  // Level flags straight from the registered count.
  assign empty = (cnt == '0);
  assign full  = (cnt == (ADDR_WIDTH+1)'(DEPTH - 1));

  // A simultaneous wr+rd is a no-op rather than a pass-through.
  assign wr_ok_c = wr & ~rd & ~full;
  assign rd_ok_c = rd & ~wr & ~empty;

  // Next-state for pointers and count; pointers wrap modulo DEPTH.
  always_comb begin
    wptr_d = wptr;
    rptr_d = rptr;
    cnt_d  = cnt;
    if (wr_ok_c) begin
      wptr_d = wptr + ADDR_WIDTH'(1);
      cnt_d  = cnt + (ADDR_WIDTH+1)'(1);
    end
    if (rd_ok_c) begin
      rptr_d = rptr + ADDR_WIDTH'(1);
      cnt_d  = cnt - (ADDR_WIDTH+1)'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      wptr <= wptr_d;
      rptr <= rptr_d;
      cnt  <= cnt_d;
    end
  end

  sync_fifo_mem u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok_c),
    .waddr (wptr),
    .wdata (din),
    .re    (rd_ok_c),
    .raddr (rptr),
    .rdata (dout)
  );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, corner-case
// sequences, and a random run against a queue-based reference model.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       empty;
  logic       full;

  int n_chk;
  int n_err;

  // Reference model: contents as a queue, dout as last popped byte,
  // pointers as running totals of accepted operations.
  logic [7:0] q [$];
  logic [7:0] m_dout;
  int         m_wtot;
  int         m_rtot;

  typedef struct {
    bit         r;
    bit         w;
    bit         rr;
    logic [7:0] d;
    bit         e_empty;
    bit         e_full;
    logic [7:0] e_dout;
    logic [4:0] e_cnt;
  } vec_t;

  vec_t tbl [$];

  sync_fifo dut (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .rd    (rd),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, then sample 1 time unit after the edge.
  task automatic step(input bit r, input bit w, input bit rr, input logic [7:0] d);
    rst = r;
    wr  = w;
    rd  = rr;
    din = d;
    if (!r) begin
      q.delete();
      m_dout = 8'h00;
      m_wtot = 0;
      m_rtot = 0;
    end else if (w && !rr && q.size() < 15) begin
      q.push_back(d);
      m_wtot++;
    end else if (rr && !w && q.size() > 0) begin
      m_dout = q.pop_front();
      m_rtot++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},  32'(dout),     32'(m_dout));
    chk({tag, ".empty"}, 32'(empty),    32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),     32'(q.size() == 15));
    chk({tag, ".cnt"},   32'(dut.cnt),  32'(q.size()));
    chk({tag, ".wptr"},  32'(dut.wptr), 32'(m_wtot % 16));
    chk({tag, ".rptr"},  32'(dut.rptr), 32'(m_rtot % 16));
  endtask

  task automatic add(input bit r, input bit w, input bit rr, input logic [7:0] d,
                     input bit ee, input bit ef, input logic [7:0] edo, input logic [4:0] ec);
    vec_t v;
    v.r = r; v.w = w; v.rr = rr; v.d = d;
    v.e_empty = ee; v.e_full = ef; v.e_dout = edo; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  logic [7:0] data [15];
  logic [7:0] saved;
  logic [7:0] mem15;

  initial begin
    n_chk = 0;
    n_err = 0;
    m_dout = 8'h00;
    m_wtot = 0;
    m_rtot = 0;
    rst = 1'b0;
    wr  = 1'b0;
    rd  = 1'b0;
    din = 8'h00;

    // Reset with all wr/rd combinations, then a short byte exchange.
    add(0, 0, 0, 8'h11, 1, 0, 8'h00, 5'd0);
    add(0, 0, 1, 8'h22, 1, 0, 8'h00, 5'd0);
    add(0, 1, 0, 8'h33, 1, 0, 8'h00, 5'd0);
    add(0, 1, 1, 8'h44, 1, 0, 8'h00, 5'd0);
    add(1, 1, 0, 8'hA5, 0, 0, 8'h00, 5'd1);
    add(1, 1, 0, 8'h3C, 0, 0, 8'h00, 5'd2);
    add(1, 0, 1, 8'h00, 0, 0, 8'hA5, 5'd1);
    add(1, 1, 1, 8'h77, 0, 0, 8'hA5, 5'd1);
    add(1, 0, 1, 8'h00, 1, 0, 8'h3C, 5'd0);
    add(1, 0, 1, 8'h00, 1, 0, 8'h3C, 5'd0);
    add(1, 0, 0, 8'h00, 1, 0, 8'h3C, 5'd0);
    add(1, 1, 0, 8'h5A, 0, 0, 8'h3C, 5'd1);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].rr, tbl[i].d);
      chk($sformatf("vec%0d.empty", i), 32'(empty),   32'(tbl[i].e_empty));
      chk($sformatf("vec%0d.full", i),  32'(full),    32'(tbl[i].e_full));
      chk($sformatf("vec%0d.dout", i),  32'(dout),    32'(tbl[i].e_dout));
      chk($sformatf("vec%0d.cnt", i),   32'(dut.cnt), 32'(tbl[i].e_cnt));
      check_model($sformatf("vec%0d", i));
    end

    // Fill to capacity.
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 15; i++) begin
      data[i] = 8'($urandom);
      step(1, 1, 0, data[i]);
      chk($sformatf("fill%0d.cnt", i),   32'(dut.cnt), 32'(i + 1));
      chk($sformatf("fill%0d.empty", i), 32'(empty),   32'(0));
      chk($sformatf("fill%0d.full", i),  32'(full),    32'(i == 14));
    end
    chk("fill.wptr", 32'(dut.wptr), 32'(15));

    // Write against a full FIFO must be dropped.
    mem15 = dut.u_mem.mem[15];
    step(1, 1, 0, ~data[0]);
    chk("wfull.cnt",  32'(dut.cnt),  32'(15));
    chk("wfull.wptr", 32'(dut.wptr), 32'(15));
    chk("wfull.full", 32'(full),     32'(1));
    chk("wfull.mem",  32'(dut.u_mem.mem[15]), 32'(mem15));

    // Drain in order, then one read against empty.
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 1, 8'h00);
      chk($sformatf("drain%0d.dout", i),  32'(dout),  32'(data[i]));
      chk($sformatf("drain%0d.empty", i), 32'(empty), 32'(i == 14));
    end
    step(1, 0, 1, 8'h00);
    chk("rempty.dout", 32'(dout),     32'(data[14]));
    chk("rempty.rptr", 32'(dut.rptr), 32'(15));
    chk("rempty.cnt",  32'(dut.cnt),  32'(0));

    // Simultaneous wr+rd at cnt=5 is a no-op.
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      data[i] = 8'($urandom);
      step(1, 1, 0, data[i]);
    end
    step(1, 0, 1, 8'h00);
    step(1, 1, 1, 8'hEE);
    chk("both.cnt",  32'(dut.cnt),  32'(5));
    chk("both.wptr", 32'(dut.wptr), 32'(6));
    chk("both.rptr", 32'(dut.rptr), 32'(1));
    chk("both.dout", 32'(dout),     32'(data[0]));

    // Wrap: pointers roll past 15 with FIFO order intact.
    step(0, 0, 0, 8'h00);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) begin
        data[i] = 8'($urandom);
        step(1, 1, 0, data[i]);
      end
      for (int i = 0; i < 10; i++) begin
        step(1, 0, 1, 8'h00);
        chk($sformatf("wrap%0d_%0d.dout", pass, i), 32'(dout), 32'(data[i]));
      end
    end
    chk("wrap.wptr", 32'(dut.wptr), 32'(4));
    chk("wrap.rptr", 32'(dut.rptr), 32'(4));

    // Random traffic with occasional mid-run resets.
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 2000; i++) begin
      bit r, w, rr;
      r  = ($urandom_range(0, 199) != 0);
      w  = ($urandom_range(0, 99) < (i % 400 < 200 ? 65 : 35));
      rr = ($urandom_range(0, 99) < (i % 400 < 200 ? 35 : 65));
      step(r, w, rr, 8'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_sync_fifo
